// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer with oversampled bit timing
// Optional macro UART_TX_CTS_EN adds cts_n_i flow control on frame start.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_pulse_i,
  input  logic [7:0]        lcr_i,
  input  logic              tx_fifo_empty_i,
  input  logic [DATA_W-1:0] tx_fifo_data_i,
`ifdef UART_TX_CTS_EN
  input  logic              cts_n_i,
`endif
  output logic              tx_pop_o,
  output logic              tx_o,
  output logic              tx_busy_o,
  output logic              temt_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] L_BIT    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] L_STOP15 = TW'(3 * OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] L_STOP2  = TW'(2 * OVERSAMPLE - 1);

  state_t            r_state;
  logic [TW-1:0]     r_tick;
  logic [2:0]        r_bit;
  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_lcr;
  logic              r_par;
  logic              r_line;
  logic              r_tx;
  logic              r_busy;
  logic              r_temt;

  logic              w_cts_ok;
  logic              w_pop;
  logic [TW-1:0]     w_tick_last;
  logic              w_bit_end;
  logic              w_last_data;
  logic [DATA_W-1:0] w_mask;
  logic              w_xor;
  logic              w_par_bit;
  logic              w_line_nxt;
  logic              w_unused;

`ifdef UART_TX_CTS_EN
  assign w_cts_ok = ~cts_n_i;
`else
  assign w_cts_ok = 1'b1;
`endif

  assign w_unused    = lcr_i[7];
  assign w_pop       = (r_state == S_IDLE) & ~tx_fifo_empty_i & w_cts_ok & ~rst;
  assign w_bit_end   = baud_pulse_i & (r_tick == w_tick_last);
  assign w_last_data = (r_bit == ({1'b0, r_lcr[1:0]} + 3'd4));

  // Parity is resolved at capture so the shift register can be consumed freely.
  assign w_mask    = {DATA_W{1'b1}} >> (2'd3 - lcr_i[1:0]);
  assign w_xor     = ^(tx_fifo_data_i & w_mask);
  assign w_par_bit = lcr_i[5] ? ~lcr_i[4] : (lcr_i[4] ? w_xor : ~w_xor);

  always_comb begin
    w_tick_last = L_BIT;
    if (r_state == S_STOP && r_lcr[2])
      w_tick_last = (r_lcr[1:0] == 2'b00) ? L_STOP15 : L_STOP2;
  end

  always_comb begin
    w_line_nxt = r_line;
    case (r_state)
      S_IDLE:   w_line_nxt = ~w_pop;
      S_START:  if (w_bit_end) w_line_nxt = r_shift[0];
      S_DATA:   if (w_bit_end)
                  w_line_nxt = w_last_data ? (r_lcr[3] ? r_par : 1'b1) : r_shift[1];
      S_PARITY: if (w_bit_end) w_line_nxt = 1'b1;
      default:  w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_lcr   <= '0;
      r_par   <= 1'b0;
      r_line  <= 1'b1;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_temt  <= 1'b1;
    end else begin
      r_line <= w_line_nxt;
      r_tx   <= w_line_nxt & ~lcr_i[6];
      r_temt <= tx_fifo_empty_i & ~r_busy & ~w_pop;
      if (r_state != S_IDLE && baud_pulse_i)
        r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_busy <= w_pop;
          if (w_pop) begin
            r_shift <= tx_fifo_data_i;
            r_lcr   <= lcr_i[3:0];
            r_par   <= w_par_bit;
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= S_START;
          end
        end
        S_START: if (w_bit_end) r_state <= S_DATA;
        S_DATA: if (w_bit_end) begin
          r_shift <= r_shift >> 1;
          if (w_last_data) r_state <= r_lcr[3] ? S_PARITY : S_STOP;
          else             r_bit   <= r_bit + 1'b1;
        end
        S_PARITY: if (w_bit_end) r_state <= S_STOP;
        S_STOP: if (w_bit_end) begin
          // Keep busy through the single idle cycle when another frame follows.
          r_state <= S_IDLE;
          r_busy  <= ~tx_fifo_empty_i & w_cts_ok;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_pop_o  = w_pop;
  assign tx_o      = r_tx;
  assign tx_busy_o = r_busy;
  assign temt_o    = r_temt;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer
module tb_uart_tx_serializer;
  localparam int OS = 16;

  typedef struct {
    logic [7:0] d;
    logic [7:0] l;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_pulse_i = 1'b0;
  logic [7:0] lcr_i = 8'h03;
  logic       tx_fifo_empty_i = 1'b1;
  logic [7:0] tx_fifo_data_i = 8'h00;
  logic       tx_pop_o;
  logic       tx_o;
  logic       tx_busy_o;
  logic       temt_o;
`ifdef UART_TX_CTS_EN
  logic       cts_n_i = 1'b0;
  logic       nxt_cts = 1'b0;
`endif

  logic       nxt_rst = 1'b1;
  logic [7:0] nxt_lcr = 8'h03;
  int         baud_div = 1;
  int         baud_cnt = 0;
  logic [7:0] fifo_q[$];
  frame_t     exp_fr[$];
  logic       exp_lv[$];
  logic       obs_q[$];
  logic       pend = 1'b0;
  logic       prev_brk = 1'b0;
  int         cyc = 0;
  int         pops = 0;
  int         last_pop = 0;
  int         frame_len = 0;
  int         last_len = 0;
  int         busy_cnt = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .baud_pulse_i    (baud_pulse_i),
    .lcr_i           (lcr_i),
    .tx_fifo_empty_i (tx_fifo_empty_i),
    .tx_fifo_data_i  (tx_fifo_data_i),
`ifdef UART_TX_CTS_EN
    .cts_n_i         (cts_n_i),
`endif
    .tx_pop_o        (tx_pop_o),
    .tx_o            (tx_o),
    .tx_busy_o       (tx_busy_o),
    .temt_o          (temt_o)
  );

  function automatic void gen_frame(input logic [7:0] d, input logic [7:0] l);
    int   n;
    int   stop_len;
    logic x;
    logic p;
    n = 5 + int'(l[1:0]);
    x = 1'b0;
    for (int i = 0; i < OS; i++) exp_lv.push_back(1'b0);
    for (int b = 0; b < n; b++) begin
      x ^= d[b];
      for (int i = 0; i < OS; i++) exp_lv.push_back(d[b]);
    end
    if (l[3]) begin
      p = l[5] ? ~l[4] : (l[4] ? x : ~x);
      for (int i = 0; i < OS; i++) exp_lv.push_back(p);
    end
    stop_len = !l[2] ? OS : ((n == 5) ? OS * 3 / 2 : OS * 2);
    for (int i = 0; i < stop_len; i++) exp_lv.push_back(1'b1);
  endfunction

  task automatic push(input logic [7:0] d);
    frame_t f;
    f.d = d;
    f.l = nxt_lcr;
    fifo_q.push_back(d);
    exp_fr.push_back(f);
  endtask

  task automatic step();
    frame_t f;
    logic   want_tx;
    @(negedge clk);
    prev_brk = lcr_i[6];
    if (pend) begin
      fifo_q.delete(0);
      pend = 1'b0;
    end
    rst   = nxt_rst;
    lcr_i = nxt_lcr;
`ifdef UART_TX_CTS_EN
    cts_n_i = nxt_cts;
`endif
    baud_pulse_i    = (baud_cnt == 0);
    baud_cnt        = (baud_cnt + 1 >= baud_div) ? 0 : baud_cnt + 1;
    tx_fifo_empty_i = (fifo_q.size() == 0);
    tx_fifo_data_i  = tx_fifo_empty_i ? 8'h00 : fifo_q[0];
    #1;
    cyc++;
    want_tx = (exp_lv.size() > 0 ? exp_lv[0] : 1'b1) & ~prev_brk;
    total++;
    if (tx_o !== want_tx) begin
      bad++;
      $display("FAIL tx_line cyc=%0d got=%b want=%b", cyc, tx_o, want_tx);
    end
    if (exp_lv.size() > 0) begin
      total++;
      if (tx_busy_o !== 1'b1) begin
        bad++;
        $display("FAIL busy_in_frame cyc=%0d got=%b want=1", cyc, tx_busy_o);
      end
      obs_q.push_back(tx_o);
      frame_len++;
      if (baud_pulse_i) begin
        exp_lv.delete(0);
        if (exp_lv.size() == 0) last_len = frame_len;
      end
    end
    if (tx_busy_o === 1'b1) busy_cnt++;
    if (tx_pop_o === 1'b1) begin
      total++;
      if (tx_fifo_empty_i !== 1'b0 || exp_lv.size() != 0 || exp_fr.size() == 0) begin
        bad++;
        $display("FAIL pop_legal cyc=%0d got empty=%b in_frame=%0d queued=%0d want empty=0 in_frame=0 queued>0",
                 cyc, tx_fifo_empty_i, exp_lv.size(), exp_fr.size());
      end else begin
        f = exp_fr.pop_front();
        gen_frame(f.d, f.l);
      end
      pend      = 1'b1;
      pops++;
      last_pop  = cyc;
      frame_len = 0;
      obs_q.delete();
    end
    if (rst) exp_lv.delete();
  endtask

  task automatic wait_pop(input string tag);
    int start;
    start = pops;
    for (int i = 0; i < 400 && pops == start; i++) step();
    total++;
    if (pops == start) begin
      bad++;
      $display("FAIL %s_pop_timeout got pops=%0d want=%0d", tag, pops, start + 1);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && (exp_lv.size() > 0 || fifo_q.size() > 0 || pend || exp_fr.size() > 0); i++)
      step();
    total++;
    if (exp_lv.size() > 0 || exp_fr.size() > 0) begin
      bad++;
      $display("FAIL %s_done_timeout got left=%0d frames=%0d want 0 0", tag, exp_lv.size(), exp_fr.size());
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] want);
    logic [7:0] got;
    got = 8'h00;
    if (obs_q.size() >= OS * 9)
      for (int k = 0; k < 8; k++) got[k] = obs_q[OS * (k + 1) + OS / 2];
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s_data got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic test_reset();
    nxt_rst = 1'b1;
    push(8'h81);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || temt_o !== 1'b1 || tx_pop_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_state got tx=%b busy=%b temt=%b pop=%b want 1 0 1 0",
                 tx_o, tx_busy_o, temt_o, tx_pop_o);
      end
    end
    nxt_rst = 1'b0;
    wait_done("reset_release");
    check_byte("reset_release", 8'h81);
  endtask

  task automatic test_8n1();
    int p0;
    repeat (3) step();
    p0 = pops;
    busy_cnt = 0;
    push(8'h55);
    wait_done("8n1");
    total++;
    if (pops - p0 != 1) begin
      bad++;
      $display("FAIL 8n1_pops got=%0d want=1", pops - p0);
    end
    total++;
    if (last_len != OS * 10) begin
      bad++;
      $display("FAIL 8n1_len got=%0d want=%0d", last_len, OS * 10);
    end
    check_byte("8n1", 8'h55);
    step();
    step();
    total++;
    if (busy_cnt != OS * 10) begin
      bad++;
      $display("FAIL 8n1_busy got=%0d want=%0d", busy_cnt, OS * 10);
    end
    total++;
    if (temt_o !== 1'b1) begin
      bad++;
      $display("FAIL 8n1_temt got=%b want=1", temt_o);
    end
  endtask

  task automatic test_parity();
    logic [7:0] lcrs[3];
    logic       wants[3];
    lcrs  = '{8'h1B, 8'h0B, 8'h3B};
    wants = '{1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 3; t++) begin
      nxt_lcr = lcrs[t];
      step();
      push(8'h07);
      wait_done("parity");
      total++;
      if (last_len != OS * 11 || obs_q[OS * 9 + OS / 2] !== wants[t]) begin
        bad++;
        $display("FAIL parity_lcr%h got len=%0d bit=%b want len=%0d bit=%b",
                 lcrs[t], last_len, obs_q[OS * 9 + OS / 2], OS * 11, wants[t]);
      end
    end
    nxt_lcr = 8'h03;
  endtask

  task automatic test_stop();
    logic [7:0] lcrs[2];
    int         lens[2];
    lcrs = '{8'h04, 8'h07};
    lens = '{OS * 6 + 24, OS * 9 + 32};
    for (int t = 0; t < 2; t++) begin
      nxt_lcr = lcrs[t];
      step();
      push(8'hFF);
      wait_done("stop");
      total++;
      if (last_len != lens[t]) begin
        bad++;
        $display("FAIL stop_len_lcr%h got=%0d want=%0d", lcrs[t], last_len, lens[t]);
      end
    end
    nxt_lcr = 8'h03;
    step();
  endtask

  task automatic test_back_to_back();
    int p1;
    int p2;
    int lows;
    int base;
    base = pops;
    push(8'hA5);
    push(8'h3C);
    wait_pop("b2b");
    p1   = last_pop;
    p2   = 0;
    lows = 0;
    for (int i = 0; i < 600 && !(pops == base + 2 && exp_lv.size() == 0); i++) begin
      step();
      if (pops == base + 2 && p2 == 0) p2 = last_pop;
      if (tx_busy_o !== 1'b1) lows++;
    end
    total++;
    if (pops - base != 2 || p2 - p1 != OS * 10 + 1) begin
      bad++;
      $display("FAIL b2b_gap got pops=%0d gap=%0d want 2 %0d", pops - base, p2 - p1, OS * 10 + 1);
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL b2b_busy got low_cycles=%0d want=0", lows);
    end
    check_byte("b2b_second", 8'h3C);
  endtask

  task automatic test_lcr_change();
    nxt_lcr = 8'h03;
    push(8'h5A);
    wait_pop("lcr_change");
    repeat (40) step();
    nxt_lcr = 8'h00;
    step();
    total++;
    if (temt_o !== 1'b0) begin
      bad++;
      $display("FAIL lcr_change_temt got=%b want=0", temt_o);
    end
    wait_done("lcr_change");
    total++;
    if (last_len != OS * 10) begin
      bad++;
      $display("FAIL lcr_change_len got=%0d want=%0d", last_len, OS * 10);
    end
    check_byte("lcr_change", 8'h5A);
    nxt_lcr = 8'h03;
    step();
  endtask

  task automatic test_break();
    push(8'hF0);
    wait_pop("break");
    repeat (100) step();
    nxt_lcr = 8'h43;
    step();
    step();
    total++;
    if (tx_o !== 1'b0) begin
      bad++;
      $display("FAIL break_force got=%b want=0", tx_o);
    end
    repeat (10) step();
    nxt_lcr = 8'h03;
    step();
    step();
    total++;
    if (tx_o !== 1'b1) begin
      bad++;
      $display("FAIL break_release got=%b want=1", tx_o);
    end
    wait_done("break");
  endtask

  task automatic test_reset_mid();
    int p;
    push(8'h96);
    wait_pop("reset_mid");
    repeat (50) step();
    nxt_rst = 1'b1;
    step();
    nxt_rst = 1'b0;
    p = pops;
    step();
    total++;
    if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_pop_o !== 1'b0 || temt_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got tx=%b busy=%b pop=%b temt=%b want 1 0 0 1",
               tx_o, tx_busy_o, tx_pop_o, temt_o);
    end
    repeat (5) step();
    total++;
    if (pops != p) begin
      bad++;
      $display("FAIL reset_mid_pops got=%0d want=%0d", pops, p);
    end
  endtask

  task automatic test_slow_baud();
    baud_div = 3;
    push(8'hC3);
    wait_done("slow_baud");
    baud_div = 1;
    baud_cnt = 0;
    step();
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    int p;
    nxt_cts = 1'b1;
    step();
    push(8'h11);
    p = pops;
    repeat (100) step();
    total++;
    if (pops != p) begin
      bad++;
      $display("FAIL cts_block got pops=%0d want=%0d", pops, p);
    end
    nxt_cts = 1'b0;
    step();
    total++;
    if (tx_pop_o !== 1'b1) begin
      bad++;
      $display("FAIL cts_release_pop got=%b want=1", tx_pop_o);
    end
    repeat (30) step();
    push(8'h22);
    nxt_cts = 1'b1;
    for (int i = 0; i < 400 && exp_lv.size() > 0; i++) step();
    repeat (50) step();
    total++;
    if (pops != p + 1 || fifo_q.size() != 1 || last_len != OS * 10) begin
      bad++;
      $display("FAIL cts_hold got pops=%0d fifo=%0d len=%0d want %0d 1 %0d",
               pops - p, fifo_q.size(), last_len, 1, OS * 10);
    end
    nxt_cts = 1'b0;
    wait_done("cts");
    check_byte("cts_second", 8'h22);
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop();
    test_back_to_back();
    test_lcr_change();
    test_break();
    test_reset_mid();
    test_slow_baud();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
